// File: rtl/rr_decode_arbiter_16_if.sv
// -----------------------------------------------------------------------------
// rr_decode_arbiter_16_if
//
// Bundles the request/grant signals of the 16-way round-robin arbiter.
//
// Signals:
//   en        requester side -> arbiter : arbitration enable (gates new grants)
//   req[15:0] requester side -> arbiter : request vector, bit n = requester n
//   gnt[15:0] arbiter -> requester side : one-hot grant, all-zero when idle
//   gnt_id    arbiter -> requester side : binary index of the current grantee
//   gnt_valid arbiter -> requester side : high while a grant is held
//   timeout   arbiter -> requester side : one-cycle pulse on a forced release
//
// Modports:
//   master : the requester side (drives en/req, observes the grant)
//   slave  : the arbiter (observes en/req, drives the grant)
// -----------------------------------------------------------------------------
interface rr_decode_arbiter_16_if;

    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_decode_arbiter_16.sv
// -----------------------------------------------------------------------------
// rr_decode_arbiter_16
//
// Round-robin arbiter sharing one resource among 16 requesters. A 4-bit
// winner index is chosen by a circular search starting at the priority
// pointer, then decoded 4-to-16 into a one-hot grant. A grant is held until
// its owner drops the request or, when MAX_HOLD is non-zero, until it has
// been held MAX_HOLD consecutive cycles.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles (0 disables the timeout),
//             legal range 0..255
//
// Ports:
//   clk   input   single clock, all state updates on the rising edge
//   rst   input   synchronous, active-high reset; aborts any grant in progress
//   bus   slave   request/grant bundle (en, req in; gnt, gnt_id, gnt_valid,
//                 timeout out); every output is a register
// -----------------------------------------------------------------------------
module rr_decode_arbiter_16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    rr_decode_arbiter_16_if.slave       bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit         HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // 4-to-16 one-hot decode of the winner index.
    function automatic logic [15:0] decode_1h(input logic [3:0] idx);
        logic [15:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Circular search from ptr upward: ptr, ptr+1, ..., 15, 0, ..., ptr-1.
    // Returns {found, index}. The loop runs from the farthest offset down to
    // offset 0 so that the nearest set bit is the last one written.
    function automatic logic [4:0] find_winner(input logic [15:0] req,
                                               input logic [3:0]  ptr);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            idx = ptr + 4'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Hold counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_ptr;
    logic [7:0]  r_hold;
    logic [15:0] r_gnt;
    logic [3:0]  r_gnt_id;
    logic        r_gnt_valid;
    logic        r_timeout;

    state_t      w_state_nxt;
    logic [3:0]  w_ptr_nxt;
    logic [7:0]  w_hold_nxt;
    logic [15:0] w_gnt_nxt;
    logic [3:0]  w_gnt_id_nxt;
    logic        w_gnt_valid_nxt;
    logic        w_timeout_nxt;

    logic [4:0]  w_pick;
    logic        w_found;
    logic [3:0]  w_winner;
    logic        w_owner_req;
    logic        w_hold_hit;

    assign w_pick      = find_winner(bus.req, r_ptr);
    assign w_found     = w_pick[4];
    assign w_winner    = w_pick[3:0];
    assign w_owner_req = bus.req[r_gnt_id];
    // Only meaningful in BUSY; the counter is 1 on the first granted cycle.
    assign w_hold_hit  = HOLD_EN && (r_hold == HOLD_LIMIT);

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.en && w_found) begin
                    w_state_nxt     = BUSY;
                    w_gnt_id_nxt    = w_winner;
                    w_gnt_nxt       = decode_1h(w_winner);
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = 8'd1;
                end else begin
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                end
            end

            BUSY: begin
                // en is deliberately ignored here: it only blocks new grants.
                if (!w_owner_req || w_hold_hit) begin
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_id + 4'd1;
                    // A simultaneous request drop counts as a normal release.
                    w_timeout_nxt   = w_owner_req && w_hold_hit;
                end else begin
                    w_hold_nxt      = sat_inc(r_hold);
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 4'h0;
            r_hold      <= 8'h00;
            r_gnt       <= 16'h0000;
            r_gnt_id    <= 4'h0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold      <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter_16.sv
// -----------------------------------------------------------------------------
// tb_rr_decode_arbiter_16
//
// Directed testbench for rr_decode_arbiter_16 with MAX_HOLD = 8. Inputs are
// driven 1 ns after a rising edge and outputs are sampled at the same point,
// so each sample shows the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_rr_decode_arbiter_16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   mon_en;

    rr_decode_arbiter_16_if bus ();

    rr_decode_arbiter_16 #(
        .MAX_HOLD (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant/index consistency on every falling edge once reset has settled.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.gnt !== (bus.gnt_valid ? (16'h0001 << bus.gnt_id) : 16'h0000)) begin
                failures++;
                $display("FAIL invariant gnt=%h gnt_id=%0d gnt_valid=%b", bus.gnt, bus.gnt_id, bus.gnt_valid);
            end
        end
    end

    task automatic test_reset();
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.req = 16'h0000;
        step();
        step();
        mon_en = 1'b1;
        checks++;
        if (bus.gnt !== 16'h0000) begin failures++; $display("FAIL reset_gnt actual=%h expected=0000", bus.gnt); end
        checks++;
        if (bus.gnt_id !== 4'h0) begin failures++; $display("FAIL reset_gnt_id actual=%h expected=0", bus.gnt_id); end
        checks++;
        if (bus.gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_gnt_valid actual=%b expected=0", bus.gnt_valid); end
        checks++;
        if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout actual=%b expected=0", bus.timeout); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.en  = 1'b1;
        bus.req = 16'h0010;
        step();
        checks++;
        if (bus.gnt !== 16'h0010) begin failures++; $display("FAIL single_gnt actual=%h expected=0010", bus.gnt); end
        checks++;
        if (bus.gnt_id !== 4'd4) begin failures++; $display("FAIL single_gnt_id actual=%0d expected=4", bus.gnt_id); end
        checks++;
        if (bus.gnt_valid !== 1'b1) begin failures++; $display("FAIL single_valid actual=%b expected=1", bus.gnt_valid); end
        bus.req = 16'h0000;
        step();
        checks++;
        if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0) begin
            failures++; $display("FAIL single_release gnt=%h valid=%b expected gnt=0000 valid=0", bus.gnt, bus.gnt_valid);
        end
        checks++;
        if (bus.gnt_id !== 4'd4) begin failures++; $display("FAIL single_id_retained actual=%0d expected=4", bus.gnt_id); end
    endtask

    // ptr is 5 after test_single, so the full-request rotation starts at 5
    // and runs 5..15, 0..15, leaving ptr at 0.
    task automatic test_rotation();
        logic [3:0]  exp_id;
        logic [15:0] exp_gnt;
        bus.req = 16'hFFFF;
        for (int k = 0; k < 27; k++) begin
            exp_id  = 4'((5 + k) % 16);
            exp_gnt = 16'h0001 << exp_id;
            step();
            checks++;
            if (bus.gnt !== exp_gnt || bus.gnt_id !== exp_id) begin
                failures++; $display("FAIL rot_grant k=%0d gnt=%h id=%0d expected gnt=%h id=%0d", k, bus.gnt, bus.gnt_id, exp_gnt, exp_id);
            end
            step();
            checks++;
            if (bus.gnt !== exp_gnt) begin
                failures++; $display("FAIL rot_hold k=%0d gnt=%h expected=%h", k, bus.gnt, exp_gnt);
            end
            bus.req = 16'hFFFF & ~exp_gnt;
            step();
            checks++;
            if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0) begin
                failures++; $display("FAIL rot_gap k=%0d gnt=%h valid=%b expected gnt=0000 valid=0", k, bus.gnt, bus.gnt_valid);
            end
            bus.req = 16'hFFFF;
        end
        bus.req = 16'h0000;
        step();
    endtask

    task automatic test_wrap();
        bus.req = 16'h8001;
        step();
        checks++;
        if (bus.gnt !== 16'h0001 || bus.gnt_id !== 4'd0) begin
            failures++; $display("FAIL wrap_first gnt=%h id=%0d expected gnt=0001 id=0", bus.gnt, bus.gnt_id);
        end
        bus.req = 16'h8000;
        step();
        checks++;
        if (bus.gnt !== 16'h0000) begin failures++; $display("FAIL wrap_gap gnt=%h expected=0000", bus.gnt); end
        bus.req = 16'h8001;
        step();
        checks++;
        if (bus.gnt !== 16'h8000 || bus.gnt_id !== 4'd15) begin
            failures++; $display("FAIL wrap_second gnt=%h id=%0d expected gnt=8000 id=15", bus.gnt, bus.gnt_id);
        end
        bus.req = 16'h0000;
        step();
        checks++;
        if (bus.gnt !== 16'h0000) begin failures++; $display("FAIL wrap_release gnt=%h expected=0000", bus.gnt); end
    endtask

    // ptr is 0 here (15 wraps to 0).
    task automatic test_timeout();
        bus.req = 16'h0009;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (bus.gnt !== 16'h0001 || bus.timeout !== 1'b0) begin
                failures++; $display("FAIL to_hold0 c=%0d gnt=%h timeout=%b expected gnt=0001 timeout=0", c, bus.gnt, bus.timeout);
            end
        end
        step();
        checks++;
        if (bus.gnt !== 16'h0000 || bus.timeout !== 1'b1 || bus.gnt_valid !== 1'b0) begin
            failures++; $display("FAIL to_pulse0 gnt=%h timeout=%b valid=%b expected gnt=0000 timeout=1 valid=0", bus.gnt, bus.timeout, bus.gnt_valid);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (bus.gnt !== 16'h0008 || bus.gnt_id !== 4'd3 || bus.timeout !== 1'b0) begin
                failures++; $display("FAIL to_hold3 c=%0d gnt=%h id=%0d timeout=%b expected gnt=0008 id=3 timeout=0", c, bus.gnt, bus.gnt_id, bus.timeout);
            end
        end
        step();
        checks++;
        if (bus.gnt !== 16'h0000 || bus.timeout !== 1'b1) begin
            failures++; $display("FAIL to_pulse3 gnt=%h timeout=%b expected gnt=0000 timeout=1", bus.gnt, bus.timeout);
        end
        step();
        checks++;
        if (bus.gnt !== 16'h0001 || bus.timeout !== 1'b0) begin
            failures++; $display("FAIL to_back0 gnt=%h timeout=%b expected gnt=0001 timeout=0", bus.gnt, bus.timeout);
        end
        // Seven more cycles reach the limit; then drop the request on the
        // limit edge itself, which must be a normal release with no pulse.
        for (int c = 0; c < 7; c++) begin
            step();
        end
        checks++;
        if (bus.gnt !== 16'h0001) begin failures++; $display("FAIL to_pre_limit gnt=%h expected=0001", bus.gnt); end
        bus.req = 16'h0008;
        step();
        checks++;
        if (bus.gnt !== 16'h0000 || bus.timeout !== 1'b0) begin
            failures++; $display("FAIL to_same_edge gnt=%h timeout=%b expected gnt=0000 timeout=0", bus.gnt, bus.timeout);
        end
        bus.req = 16'h0000;
        step();
    endtask

    // ptr is 1 here.
    task automatic test_enable();
        bus.en  = 1'b1;
        bus.req = 16'h0004;
        step();
        checks++;
        if (bus.gnt !== 16'h0004) begin failures++; $display("FAIL en_grant2 gnt=%h expected=0004", bus.gnt); end
        bus.en = 1'b0;
        step();
        step();
        checks++;
        if (bus.gnt !== 16'h0004 || bus.gnt_valid !== 1'b1) begin
            failures++; $display("FAIL en_persist gnt=%h valid=%b expected gnt=0004 valid=1", bus.gnt, bus.gnt_valid);
        end
        bus.req = 16'h00F0;
        step();
        checks++;
        if (bus.gnt !== 16'h0000) begin failures++; $display("FAIL en_release gnt=%h expected=0000", bus.gnt); end
        step();
        step();
        checks++;
        if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0) begin
            failures++; $display("FAIL en_blocked gnt=%h valid=%b expected gnt=0000 valid=0", bus.gnt, bus.gnt_valid);
        end
        bus.en = 1'b1;
        step();
        checks++;
        if (bus.gnt !== 16'h0010 || bus.gnt_id !== 4'd4) begin
            failures++; $display("FAIL en_resume gnt=%h id=%0d expected gnt=0010 id=4", bus.gnt, bus.gnt_id);
        end
        bus.req = 16'h0000;
        step();
    endtask

    // ptr is 5 here, so req=00C0 picks 6; after reset ptr=0 still picks 6.
    task automatic test_reset_mid();
        bus.req = 16'h00C0;
        step();
        checks++;
        if (bus.gnt !== 16'h0040) begin failures++; $display("FAIL rm_grant gnt=%h expected=0040", bus.gnt); end
        rst = 1'b1;
        step();
        checks++;
        if (bus.gnt !== 16'h0000 || bus.gnt_id !== 4'h0 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            failures++; $display("FAIL rm_reset gnt=%h id=%0d valid=%b timeout=%b expected all zero", bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.gnt !== 16'h0040 || bus.gnt_id !== 4'd6) begin
            failures++; $display("FAIL rm_regrant gnt=%h id=%0d expected gnt=0040 id=6", bus.gnt, bus.gnt_id);
        end
        // Both 6 and 7 request; after 6 drops, ptr=7 so 7 follows.
        bus.req = 16'h0080;
        step();
        bus.req = 16'h00C0;
        step();
        checks++;
        if (bus.gnt !== 16'h0080 || bus.gnt_id !== 4'd7) begin
            failures++; $display("FAIL rm_next gnt=%h id=%0d expected gnt=0080 id=7", bus.gnt, bus.gnt_id);
        end
        bus.req = 16'h0000;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.req  = 16'h0000;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_enable();
        test_reset_mid();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
